// File: rtl/store_buffer_pkg.sv
// Shared types and opcode ranges for the memory-stage store path.
package store_buffer_pkg;

  localparam logic [4:0] OP_W_LO = 5'd3;
  localparam logic [4:0] OP_W_HI = 5'd5;
  localparam logic [4:0] OP_H_LO = 5'd6;
  localparam logic [4:0] OP_H_HI = 5'd8;
  localparam logic [4:0] OP_B_LO = 5'd9;
  localparam logic [4:0] OP_B_HI = 5'd11;

  // One queued store, already lane-formatted.
  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [3:0]  we;
  } sb_entry_t;

endpackage

// File: rtl/store_lane_fmt.sv
// Places store data into its byte lanes and builds the byte-write mask.
module store_lane_fmt
  import store_buffer_pkg::*;
(
  input  logic [4:0]  opcode,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] data,
  output logic [31:0] wdata_c,
  output logic [3:0]  we_c,
  output logic        ok_c
);

  always_comb begin
    wdata_c = '0;
    we_c    = '0;
    ok_c    = 1'b0;
    if (opcode >= OP_W_LO && opcode <= OP_W_HI) begin
      wdata_c = data;
      we_c    = 4'b1111;
      ok_c    = 1'b1;
    end else if (opcode >= OP_H_LO && opcode <= OP_H_HI) begin
      ok_c = 1'b1;
      case (addr_lo)
        2'b00: begin
          wdata_c = {16'h0000, data[15:0]};
          we_c    = 4'b0011;
        end
        2'b01: begin
          wdata_c = {8'h00, data[15:0], 8'h00};
          we_c    = 4'b0110;
        end
        default: begin
          wdata_c = {data[15:0], 16'h0000};
          we_c    = 4'b1100;
        end
      endcase
    end else if (opcode >= OP_B_LO && opcode <= OP_B_HI) begin
      wdata_c = {24'h000000, data[7:0]} << {addr_lo, 3'b000};
      we_c    = 4'b0001 << addr_lo;
      ok_c    = 1'b1;
    end
  end

endmodule

// File: rtl/store_buffer.sv
// In-order store FIFO between the memory stage and the data memory port,
// with word-address hazard detection for loads.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_en,
  input  logic        halt,
  input  logic        st_valid,
  input  logic        st_bubble,
  input  logic [7:0]  st_exc,
  input  logic [4:0]  st_opcode,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  output logic        full,
  output logic        empty,
  input  logic        ld_check,
  input  logic [31:0] ld_addr,
  output logic        ld_hazard,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_we,
  input  logic        mem_ack
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  sb_entry_t        entries [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic [31:0] fmt_wdata_c;
  logic [3:0]  fmt_we_c;
  logic        fmt_ok_c;
  logic        enq_c;
  logic        pop_c;
  logic        ld_addr_unused;

  store_lane_fmt u_fmt (
    .opcode  (st_opcode),
    .addr_lo (st_addr[1:0]),
    .data    (st_data),
    .wdata_c (fmt_wdata_c),
    .we_c    (fmt_we_c),
    .ok_c    (fmt_ok_c)
  );

  // Loads are compared at word granularity only.
  assign ld_addr_unused = ^ld_addr[1:0];

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // Memory port is driven purely from registered state.
  assign mem_req   = !empty;
  assign mem_addr  = empty ? 32'h0 : {entries[rd_ptr].addr, 2'b00};
  assign mem_wdata = empty ? 32'h0 : entries[rd_ptr].wdata;
  assign mem_we    = empty ? 4'h0  : entries[rd_ptr].we;

  assign enq_c = clk_en && !halt && st_valid && !st_bubble && (st_exc == 8'h00)
                 && !full && fmt_ok_c;
  assign pop_c = clk_en && mem_req && mem_ack;

  always_comb begin
    ld_hazard = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (ld_check && valid[i] && (entries[i].addr == ld_addr[31:2])) begin
        ld_hazard = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        entries[i] <= '0;
      end
    end else begin
      if (pop_c) begin
        valid[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + PTR_W'(1);
      end
      // A full FIFO never enqueues and an empty one never pops, so slots never collide.
      if (enq_c) begin
        entries[wr_ptr] <= '{addr: st_addr[31:2], wdata: fmt_wdata_c, we: fmt_we_c};
        valid[wr_ptr]   <= 1'b1;
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end
      case ({enq_c, pop_c})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: doc/store_buffer.md
# store_buffer

Memory-stage store path that queues committed stores and drains them to the data memory port. It is the write-direction counterpart of writeback's load lane extraction. It inserts byte and halfword data into the correct lanes and generates a 4-bit byte-write mask, then holds the store in a small FIFO until memory accepts it. It also flags loads whose word address matches a pending store, so the pipeline can stall them.

## Interface
- DEPTH, 4, number of FIFO entries; power of two, 2..16
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- clk_en  in  1  global clock enable; no state changes while low
- halt  in  1  blocks enqueue only; draining continues
- st_valid  in  1  memory-stage slot holds a store
- st_bubble  in  1  slot is a bubble
- st_exc  in  8  exception code of the slot; nonzero kills the store
- st_opcode  in  5  3..5 word, 6..8 halfword, 9..11 byte
- st_addr  in  32  effective byte address
- st_data  in  32  store data, right-aligned
- full  out  1  FIFO holds DEPTH entries; the pipeline must stall the store
- empty  out  1  no pending stores; used as a fence for rfe, halt and sleep
- ld_check  in  1  memory-stage slot is a load
- ld_addr  in  32  load effective address
- ld_hazard  out  1  combinational; ld_check && some valid entry has an equal addr[31:2]
- mem_req  out  1  head entry presented to memory
- mem_addr  out  32  {head addr[31:2], 2'b00}
- mem_wdata  out  32  lane-shifted data
- mem_we  out  4  byte-write mask; bit i enables byte lane i
- mem_ack  in  1  memory accepted the head entry

## Operation
- Enqueue condition: `clk_en && !halt && st_valid && !st_bubble && st_exc==0 && !full && st_opcode in 3..11`. Any other opcode is ignored.
- Lane formatting, with s = addr[1:0]:
  - Word: data unchanged, we=1111.
  - Halfword: s=00 gives data[15:0], we=0011. s=01 gives data[15:0]<<8, we=0110. s=1x gives data[15:0]<<16, we=1100.
  - Byte: data[7:0]<<(8*s), we=0001<<s.
- Unused lanes of mem_wdata are zero.
- Entries are stored already formatted (word address, wdata, we), plus a valid bit.
- Drain handshake:
  - mem_req = !empty.
  - mem_addr, mem_wdata and mem_we come from the head entry and stay stable while mem_req is high and mem_ack is low.
  - The head pops on an edge where mem_req && mem_ack && clk_en.
  - mem_ack while mem_req is low is ignored.
- Enqueue and pop may happen on the same edge. The count is then unchanged and the pointers both advance.
- full is computed from the registered count, so a store is refused when the FIFO is full at the start of the cycle, even if a pop occurs on that edge. There is no same-cycle bypass.
- Pointers wrap modulo DEPTH. Count width is log2(DEPTH)+1.
- ld_hazard compares against entries only, never against the store being enqueued in the same cycle. The pipeline guarantees that a load and a store never occupy the memory stage together.
- Entries drain strictly in order; there is no merging or coalescing.

## Timing
- Reset values: count=0, pointers=0, all entry valid bits=0, empty=1, full=0, mem_req=0, mem_we=0000, mem_addr=0, mem_wdata=0, ld_hazard=0.
- Reset mid-drain discards all entries. mem_req drops on the cycle after the reset edge, even if the head was unacked.
- Store accepted at edge N: mem_req is high during cycle N+1 (one-cycle latency, entry registered).
- Pop at edge M: the next entry, if any, is presented in cycle M+1. Throughput is one store per cycle with mem_ack held high.
- Every mem_* output is a function of registered state only; there is no combinational input-to-memory path.
- While clk_en is low, all outputs hold and mem_ack is not sampled. The memory side shares the clk_en domain.

## Structure
- A shared package holds:
  - opcode range constants: OP_W_LO=3, OP_W_HI=5, OP_H_LO=6, OP_H_HI=8, OP_B_LO=9, OP_B_HI=11;
  - the entry struct (addr[31:2], wdata, we).
- One combinational sub-module, store_lane_fmt (opcode, addr[1:0], data to wdata and we), shared later by any uncached store path.
- The FIFO and control live in store_buffer. About 200 lines total.

## Test plan
- Byte store: opcode 9, addr 0x1003, data 0xAB, queue empty. Next cycle mem_req=1, mem_addr=0x1000, mem_wdata=0xAB000000, mem_we=1000. Ack pops, and empty=1 on the following cycle.
- Halfword store: opcode 6, addr 0x2001, data 0x1234BEEF. Response: wdata=0x00BEEF00, we=0110. With addr 0x2002 instead: wdata=0xBEEF0000, we=1100.
- Fill and hold: 4 word stores to 0x10, 0x14, 0x18, 0x1C with ack=0. Then full=1 and a 5th store is refused. Raise ack for 4 cycles: the stores drain in order and empty=1. Hold ack high while enqueuing: steady one store per cycle, count constant.
- Killed stores: st_exc=0x82, or st_bubble=1, or halt=1. No enqueue, empty stays 1, mem_req stays 0.
- Hazard: pending store to 0x3006 plus ld_check with ld_addr 0x3004 gives ld_hazard=1. ld_addr 0x3008 gives 0. After the entry pops, ld_addr 0x3004 gives 0.
- Reset with 3 entries pending and mem_req=1 unacked: after one rst edge, mem_req=0, empty=1, count=0. A new store then appears in cycle N+1.
